// File: rtl/mux_nx1_stream_pkg.sv
// Shared definitions for the N-to-1 streaming multiplexer.
// Its mode encoding is used both by the RTL and by anything that drives the mode pin.
package mux_nx1_stream_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so ptr+1 sits at bit 0,
// priority-encode, then un-rotate the winning index.
module rr_arbiter #(
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any
);

    logic [NUM_CH-1:0] rot_req;
    int                start;
    int                rot_idx;
    int                win_idx;

    // NOTE: every signal written here gets a default before any branch, otherwise an
    // unassigned path would infer a latch.
    always_comb begin
        start   = (int'(ptr) >= NUM_CH - 1) ? 0 : int'(ptr) + 1;
        rot_req = '0;
        rot_idx = 0;
        any     = 1'b0;
        grant   = '0;

        for (int j = 0; j < NUM_CH; j++) begin
            rot_req[j] = req[(start + j) % NUM_CH];
        end

        // Walk downward so the lowest rotated position (closest after ptr) wins.
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (rot_req[j]) begin
                rot_idx = j;
                any     = 1'b1;
            end
        end

        win_idx = (start + rot_idx) % NUM_CH;
        if (any) begin
            grant[win_idx] = 1'b1;
        end
        gnt_idx = SEL_W'(win_idx);
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-channel streaming multiplexer with valid/ready on every port, fixed or
// round-robin channel selection, and a one-beat registered output stage.
module mux_nx1_stream
    import mux_nx1_stream_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch
);

    logic [NUM_CH-1:0] fix_grant;
    logic [NUM_CH-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_gnt_idx;
    logic              rr_any;

    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  gnt_idx;
    logic              grant_any;
    logic              load;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;

    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .grant   (rr_grant),
        .gnt_idx (rr_gnt_idx),
        .any     (rr_any)
    );

    // An out-of-range sel (non-power-of-2 NUM_CH) matches no channel and grants nothing.
    always_comb begin
        fix_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                fix_grant[i] = in_valid[i];
            end
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant     = rr_grant;
            gnt_idx   = rr_gnt_idx;
            grant_any = rr_any;
        end else begin
            grant     = fix_grant;
            gnt_idx   = sel;
            grant_any = |fix_grant;
        end
    end

    assign load     = !out_valid_q || out_ready;
    assign xfer     = grant_any && load && !rst;
    assign in_ready = grant & {NUM_CH{load && !rst}};

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_data = sel_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = sel_data;
                out_ch_d   = gnt_idx;
                if (mode == MODE_RR) begin
                    rr_ptr_d = gnt_idx;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SEL_W'(NUM_CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model of the multiplexer.
module tb_mux_nx1_stream;

    localparam int NCH = 8;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic              mode;
    logic [2:0]        sel;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_ch;

    logic              rst5;
    logic [5*DW-1:0]   in_data5;
    logic [4:0]        in_valid5;
    logic [4:0]        in_ready5;
    logic              mode5;
    logic [2:0]        sel5;
    logic [DW-1:0]     out_data5;
    logic              out_valid5;
    logic              out_ready5;
    logic [2:0]        out_ch5;

    always #5 clk = ~clk;

    mux_nx1_stream #(.NUM_CH(NCH), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    mux_nx1_stream #(.NUM_CH(5), .DATA_W(DW)) dut5 (
        .clk       (clk),
        .rst       (rst5),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_ch    (out_ch5)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the output register seen as a one-entry holding slot.
    bit       m_valid = 1'b0;
    int       m_data  = 0;
    int       m_ch    = 0;
    int       m_ptr   = NCH - 1;

    function automatic int model_grant();
        if (mode == 1'b0) begin
            return (int'(sel) < NCH && in_valid[sel]) ? int'(sel) : -1;
        end
        for (int k = 1; k <= NCH; k++) begin
            if (in_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
        end
        return -1;
    endfunction

    task automatic step(input string tag);
        int             g;
        bit             ld;
        logic [NCH-1:0] exp_rdy;
        #1;
        g       = model_grant();
        ld      = !m_valid || out_ready;
        exp_rdy = '0;
        if (!rst && ld && g >= 0) exp_rdy[g] = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 0;
            m_ch    = 0;
            m_ptr   = NCH - 1;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = int'(in_data[g*DW +: DW]);
                m_ch    = g;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, "_out_data"},  32'(out_data),  m_data);
        check({tag, "_out_ch"},    32'(out_ch),    m_ch);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < NCH; i++) in_data[i*DW +: DW] = 8'hA0 + 8'(i);
    endtask

    int sparse_seq[3] = '{0, 2, 7};

    initial begin
        rst = 1'b1; mode = 1'b1; sel = '0; out_ready = 1'b1;
        in_valid = '1; set_ramp();
        rst5 = 1'b1; mode5 = 1'b0; sel5 = '0; out_ready5 = 1'b1;
        in_valid5 = '0; in_data5 = '0;

        // Reset held for two clocks with every channel requesting.
        step("rst0");
        step("rst1");
        check("rst_out_ch", 32'(out_ch), 0);
        check("rst_in_ready_comb", 32'(in_ready), 0);
        rst = 1'b0;
        step("rst_first");
        check("rst_first_ch", 32'(out_ch), 0);

        // Fixed mode stepping sel through 3..7.
        mode = 1'b0;
        for (int s = 3; s <= 7; s++) begin
            sel = 3'(s);
            step("fixed");
            check("fixed_data", 32'(out_data), 32'h A0 + 32'(s));
            check("fixed_ch", 32'(out_ch), s);
        end

        // Round-robin, all channels valid, 16 gap-free beats.
        rst = 1'b1; step("rr_rst"); rst = 1'b0;
        mode = 1'b1; in_valid = '1;
        for (int k = 0; k < 16; k++) begin
            step("rr_full");
            check("rr_full_seq", 32'(out_ch), k % NCH);
            check("rr_full_gapless", 32'(out_valid), 1);
        end

        // Sparse requests exercise the 7 -> 0 wrap.
        rst = 1'b1; step("sp_rst"); rst = 1'b0;
        in_valid = 8'b1000_0101;
        for (int k = 0; k < 6; k++) begin
            step("sparse");
            check("sparse_seq", 32'(out_ch), sparse_seq[k % 3]);
        end

        // Backpressure while holding a channel-2 beat.
        rst = 1'b1; step("bp_rst"); rst = 1'b0;
        in_valid = 8'b0000_0101;
        step("bp_fill0");
        step("bp_fill2");
        in_valid = 8'b1000_0101; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("bp_hold");
            check("bp_hold_ch", 32'(out_ch), 2);
            check("bp_hold_data", 32'(out_data), 32'h A2);
        end
        out_ready = 1'b1;
        step("bp_release");
        check("bp_release_ch", 32'(out_ch), 7);

        // Reset while a beat is stalled drops it.
        out_ready = 1'b0;
        step("rst_stall_fill");
        rst = 1'b1;
        step("rst_stall");
        check("rst_stall_valid", 32'(out_valid), 0);
        rst = 1'b0; out_ready = 1'b1;

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 3'($urandom_range(0, 7));
            in_valid  = 8'($urandom);
            in_data   = {$urandom(), $urandom()};
            out_ready = ($urandom_range(0, 9) < 7);
            step("rand");
        end

        // Five-channel instance: out-of-range select grants nothing.
        in_data5[1*DW +: DW] = 8'h55;
        in_valid5 = '1;
        sel5 = 3'd1;
        @(posedge clk); #1;
        rst5 = 1'b0;
        @(posedge clk); #1;
        check("n5_load_valid", 32'(out_valid5), 1);
        check("n5_load_data", 32'(out_data5), 32'h55);
        sel5 = 3'd6;
        #1;
        check("n5_oor_in_ready", 32'(in_ready5), 0);
        @(posedge clk); #1;
        check("n5_oor_valid", 32'(out_valid5), 0);
        check("n5_oor_data_hold", 32'(out_data5), 32'h55);
        check("n5_oor_ch_hold", 32'(out_ch5), 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
